// File: rtl/ecc_pkg.sv
// Shared types and modular helpers for the sequential EC-ElGamal encrypt engine.
package ecc_pkg;

   localparam int unsigned FE_W = 32;

   typedef logic [FE_W-1:0] fe_t;

   typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_ADDM, S_DONE} state_t;
   typedef enum logic [1:0] {U_IDLE, U_INV, U_CALC, U_ACK} ustate_t;
   typedef enum logic {OP_ADD, OP_DBL} op_t;

   typedef struct packed {
      fe_t  x;
      fe_t  y;
      logic inf;
   } point_t;

   localparam point_t INF_PT = '{x: '0, y: '0, inf: 1'b1};

   function automatic fe_t mod_add(input fe_t a, input fe_t b, input fe_t p);
      logic [FE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, p}) s = s - {1'b0, p};
      return s[FE_W-1:0];
   endfunction

   function automatic fe_t mod_sub(input fe_t a, input fe_t b, input fe_t p);
      return (a >= b) ? (a - b) : (a + p - b);
   endfunction

   function automatic fe_t mod_mul(input fe_t a, input fe_t b, input fe_t p);
      logic [2*FE_W-1:0] prod;
      prod = {{FE_W{1'b0}}, a} * {{FE_W{1'b0}}, b};
      return fe_t'(prod % {{FE_W{1'b0}}, p});
   endfunction

endpackage

// File: rtl/ecc_point_unit.sv
// Affine point add/double; lambda uses an iterative binary extended-Euclid inverse.
module ecc_point_unit
   import ecc_pkg::*;
#(
   parameter int unsigned CURVE_A = 2,
   parameter int unsigned PRIME   = 17
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_req,
   input  logic            op,
   input  logic [FE_W-1:0] ax,
   input  logic [FE_W-1:0] ay,
   input  logic [FE_W-1:0] bx,
   input  logic [FE_W-1:0] by,
   output logic            op_ack,
   output logic [FE_W-1:0] rx,
   output logic [FE_W-1:0] ry
);
   localparam fe_t P     = fe_t'(PRIME);
   localparam fe_t A_RED = fe_t'(CURVE_A % PRIME);

   ustate_t ust_q, ust_d;
   fe_t x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, num_q, num_d;
   fe_t u_q, u_d, v_q, v_d, s_q, s_d, t_q, t_d, lam_q, lam_d;
   fe_t rx_q, rx_d, ry_q, ry_d;
   logic ack_q, ack_d;
   fe_t xx, x3;

   function automatic fe_t half_mod(input fe_t s);
      logic [FE_W:0] h;
      h = s[0] ? ({1'b0, s} + {1'b0, P}) : {1'b0, s};
      return h[FE_W:1];
   endfunction

   always_comb begin
      ust_d = ust_q; x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; num_d = num_q;
      u_d = u_q; v_d = v_q; s_d = s_q; t_d = t_q; lam_d = lam_q;
      rx_d = rx_q; ry_d = ry_q; ack_d = 1'b0;
      xx = mod_mul(ax, ax, P);
      x3 = '0;
      case (ust_q)
         U_IDLE: if (op_req) begin
            x1_d = ax; y1_d = ay; s_d = fe_t'(1); t_d = '0; v_d = P;
            if (op == OP_DBL) begin
               x2_d  = ax;
               num_d = mod_add(mod_add(mod_add(xx, xx, P), xx, P), A_RED, P);
               u_d   = mod_add(ay, ay, P);
            end else begin
               x2_d  = bx;
               num_d = mod_sub(by, ay, P);
               u_d   = mod_sub(bx, ax, P);
            end
            ust_d = U_INV;
         end
         // invariants: s*den = u, t*den = v (mod P); stop once either reaches 1
         U_INV: begin
            if (u_q == fe_t'(1)) begin
               lam_d = mod_mul(num_q, s_q, P); ust_d = U_CALC;
            end else if (v_q == fe_t'(1)) begin
               lam_d = mod_mul(num_q, t_q, P); ust_d = U_CALC;
            end else if (!u_q[0]) begin
               u_d = u_q >> 1; s_d = half_mod(s_q);
            end else if (!v_q[0]) begin
               v_d = v_q >> 1; t_d = half_mod(t_q);
            end else if (u_q >= v_q) begin
               u_d = u_q - v_q; s_d = mod_sub(s_q, t_q, P);
            end else begin
               v_d = v_q - u_q; t_d = mod_sub(t_q, s_q, P);
            end
         end
         U_CALC: begin
            x3    = mod_sub(mod_sub(mod_mul(lam_q, lam_q, P), x1_q, P), x2_q, P);
            rx_d  = x3;
            ry_d  = mod_sub(mod_mul(lam_q, mod_sub(x1_q, x3, P), P), y1_q, P);
            ack_d = 1'b1;
            ust_d = U_ACK;
         end
         U_ACK:   ust_d = U_IDLE;
         default: ust_d = U_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ust_q <= U_IDLE; x1_q <= '0; y1_q <= '0; x2_q <= '0; num_q <= '0;
         u_q <= '0; v_q <= '0; s_q <= '0; t_q <= '0; lam_q <= '0;
         rx_q <= '0; ry_q <= '0; ack_q <= 1'b0;
      end else begin
         ust_q <= ust_d; x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; num_q <= num_d;
         u_q <= u_d; v_q <= v_d; s_q <= s_d; t_q <= t_d; lam_q <= lam_d;
         rx_q <= rx_d; ry_q <= ry_d; ack_q <= ack_d;
      end
   end

   assign op_ack = ack_q;
   assign rx     = rx_q;
   assign ry     = ry_q;

endmodule

// File: rtl/ecc_encrypt_seq.sv
// Sequential EC-ElGamal encryption: C1 = k*P, C2 = k*Y + M via one shared point unit.
module ecc_encrypt_seq
   import ecc_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned KWIDTH    = 8,
   parameter int unsigned PRIME     = 17,
   parameter int unsigned CURVE_A   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [KWIDTH-1:0]    k,
   input  logic [DATAWIDTH-1:0] px,
   input  logic [DATAWIDTH-1:0] py,
   input  logic [DATAWIDTH-1:0] yx,
   input  logic [DATAWIDTH-1:0] yy,
   input  logic [DATAWIDTH-1:0] mx,
   input  logic [DATAWIDTH-1:0] my,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] c1x,
   output logic [DATAWIDTH-1:0] c1y,
   output logic [DATAWIDTH-1:0] c2x,
   output logic [DATAWIDTH-1:0] c2y,
   output logic                 c1_inf,
   output logic                 c2_inf
);
   localparam int unsigned DW  = DATAWIDTH;
   localparam int unsigned KCW = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;

   state_t state_q, state_d;
   logic [KWIDTH-1:0] k_q, k_d;
   logic [KCW-1:0] bit_q, bit_d;
   logic phase_q, phase_d;   // 0: doubling step, 1: conditional add step
   logic req_q, req_d;
   op_t op_q, op_d;
   point_t acc_q, acc_d, p_q, p_d, y_q, y_d, m_q, m_d;
   logic [DW-1:0] c1hx_q, c1hx_d, c1hy_q, c1hy_d;
   logic c1hinf_q, c1hinf_d;
   logic [DW-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
   logic c1_inf_q, c1_inf_d, c2_inf_q, c2_inf_d, busy_q, busy_d, done_q, done_d;

   logic op_ack;
   fe_t res_x, res_y;
   point_t base, step_acc;
   logic step_fin, issue, bit_set;
   op_t issue_op;

   ecc_point_unit #(.CURVE_A(CURVE_A), .PRIME(PRIME)) u_point (
      .clk(clk), .rst_n(rst_n), .op_req(req_q), .op(op_q),
      .ax(acc_q.x), .ay(acc_q.y), .bx(base.x), .by(base.y),
      .op_ack(op_ack), .rx(res_x), .ry(res_y)
   );

   always_comb begin
      state_d = state_q; k_d = k_q; bit_d = bit_q; phase_d = phase_q;
      req_d = req_q; op_d = op_q; acc_d = acc_q; p_d = p_q; y_d = y_q; m_d = m_q;
      c1hx_d = c1hx_q; c1hy_d = c1hy_q; c1hinf_d = c1hinf_q;
      c1x_d = c1x_q; c1y_d = c1y_q; c2x_d = c2x_q; c2y_d = c2y_q;
      c1_inf_d = c1_inf_q; c2_inf_d = c2_inf_q; busy_d = busy_q; done_d = 1'b0;
      base     = (state_q == S_MUL1) ? p_q : ((state_q == S_MUL2) ? y_q : m_q);
      bit_set  = (state_q == S_ADDM) || k_q[bit_q];
      step_fin = 1'b0; step_acc = acc_q; issue = 1'b0; issue_op = OP_ADD;

      // Infinity and inverse-pair cases resolve locally; the rest go to the point unit.
      if (req_q) begin
         if (op_ack) begin
            step_fin = 1'b1;
            step_acc = '{x: res_x, y: res_y, inf: 1'b0};
         end
      end else if (!phase_q) begin
         if (acc_q.inf || acc_q.y == '0) begin
            step_fin = 1'b1; step_acc = INF_PT;
         end else begin
            issue = 1'b1; issue_op = OP_DBL;
         end
      end else if (!bit_set) begin
         step_fin = 1'b1;
      end else if (acc_q.inf) begin
         step_fin = 1'b1; step_acc = base;
      end else if (acc_q.x == base.x) begin
         if (acc_q.y != base.y || acc_q.y == '0) begin
            step_fin = 1'b1; step_acc = INF_PT;
         end else begin
            issue = 1'b1; issue_op = OP_DBL;
         end
      end else begin
         issue = 1'b1;
      end

      case (state_q)
         S_IDLE: if (start) begin
            k_d     = k;
            p_d     = '{x: fe_t'(px), y: fe_t'(py), inf: 1'b0};
            y_d     = '{x: fe_t'(yx), y: fe_t'(yy), inf: 1'b0};
            m_d     = '{x: fe_t'(mx), y: fe_t'(my), inf: 1'b0};
            acc_d   = INF_PT;
            bit_d   = KCW'(KWIDTH - 1);
            phase_d = 1'b0;
            req_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_MUL1;
         end
         S_MUL1, S_MUL2, S_ADDM: begin
            if (issue) begin
               req_d = 1'b1; op_d = issue_op;
            end
            if (req_q && op_ack) req_d = 1'b0;
            if (step_fin) begin
               acc_d = step_acc;
               if (state_q == S_ADDM) begin
                  c1x_d = c1hx_q; c1y_d = c1hy_q; c1_inf_d = c1hinf_q;
                  c2x_d = DW'(step_acc.x); c2y_d = DW'(step_acc.y); c2_inf_d = step_acc.inf;
                  done_d = 1'b1; busy_d = 1'b0; state_d = S_DONE;
               end else if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (bit_q != '0) begin
                     bit_d = bit_q - KCW'(1);
                  end else if (state_q == S_MUL1) begin
                     c1hx_d = DW'(step_acc.x); c1hy_d = DW'(step_acc.y); c1hinf_d = step_acc.inf;
                     acc_d = INF_PT; bit_d = KCW'(KWIDTH - 1); state_d = S_MUL2;
                  end else begin
                     phase_d = 1'b1; state_d = S_ADDM;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE; k_q <= '0; bit_q <= '0; phase_q <= 1'b0;
         req_q <= 1'b0; op_q <= OP_ADD; acc_q <= '0; p_q <= '0; y_q <= '0; m_q <= '0;
         c1hx_q <= '0; c1hy_q <= '0; c1hinf_q <= 1'b0;
         c1x_q <= '0; c1y_q <= '0; c2x_q <= '0; c2y_q <= '0;
         c1_inf_q <= 1'b0; c2_inf_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      end else begin
         state_q <= state_d; k_q <= k_d; bit_q <= bit_d; phase_q <= phase_d;
         req_q <= req_d; op_q <= op_d; acc_q <= acc_d; p_q <= p_d; y_q <= y_d; m_q <= m_d;
         c1hx_q <= c1hx_d; c1hy_q <= c1hy_d; c1hinf_q <= c1hinf_d;
         c1x_q <= c1x_d; c1y_q <= c1y_d; c2x_q <= c2x_d; c2y_q <= c2y_d;
         c1_inf_q <= c1_inf_d; c2_inf_q <= c2_inf_d; busy_q <= busy_d; done_q <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign c1x    = c1x_q;
   assign c1y    = c1y_q;
   assign c2x    = c2x_q;
   assign c2y    = c2y_q;
   assign c1_inf = c1_inf_q;
   assign c2_inf = c2_inf_q;

endmodule

// File: doc/ecc_encrypt_seq.md
Name: ecc_encrypt_seq

Overview:
- Sequential, parametrised EC-ElGamal encryption engine.
- Computes C1 = k·P and C2 = k·Y + M over the curve y² = x³ + A·x + B mod PRIME.
- Uses one shared point-arithmetic unit, time-multiplexed, with a start/done handshake.
- Successor to the combinational encrypt path. It adds point-at-infinity handling, configurable scalar width, and a busy/done protocol, so it can sit behind a bus-facing controller.

Parameters:
- DATAWIDTH, 8, coordinate width and field-element width in bits.
- KWIDTH, 8, scalar width in bits (KWIDTH ≤ DATAWIDTH not required).
- PRIME, 17, field modulus (odd prime, < 2^DATAWIDTH).
- CURVE_A, 2, curve coefficient a (B is unused by the arithmetic).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request; sampled only when busy=0.
- k  in  KWIDTH  ephemeral scalar.
- px, py  in  DATAWIDTH each  generator P.
- yx, yy  in  DATAWIDTH each  public key Y.
- mx, my  in  DATAWIDTH each  message point M (never infinity).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- c1x, c1y, c2x, c2y  out  DATAWIDTH each  ciphertext points.
- c1_inf, c2_inf  out  1 each  marks the corresponding point as infinity (its coordinates are then 0).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0; FSM goes to IDLE.
  - An in-flight operation is aborted, including a mid-operation request to the sub-unit.
  - No done pulse follows.
- Acceptance: start=1 while in IDLE latches k, P, Y and M in that cycle. busy rises in the next cycle. start while busy=1 is ignored, and the latched operands do not change.
- Inputs may change freely after acceptance.
- FSM states: IDLE → MUL1 → MUL2 → ADDM → DONE → IDLE.
- MUL1 and MUL2: left-to-right double-and-add over KWIDTH bits, MSB first.
  - Per bit: acc = 2·acc, then acc = acc + base if the bit is 1.
  - acc starts at infinity. base = P in MUL1, base = Y in MUL2.
  - A bit counter runs from KWIDTH-1 down to 0. Leaving MUL1 stores acc into the C1 register.
- ADDM: acc = acc + M.
- DONE:
  - Outputs update on entry; done=1 for exactly one cycle; busy falls in the same cycle.
  - Outputs hold until the next accepted start completes.
- Infinity rules (handled in this block, not in the sub-unit):
  - inf + Q = Q.
  - Q + inf = Q.
  - 2·inf = inf.
  - Q + (−Q) = inf, i.e. equal x with y1 ≠ y2, or with y=0 on doubling.
  - In these cases the sub-unit is not invoked.
- Sub-unit interaction: op_req is held until op_ack, one request at a time. Latency is data-dependent (the modular inverse iterates).
- Total latency bound: done ≤ (2·KWIDTH+1)·2·(LAT_MAX+2)+4 cycles after acceptance, where LAT_MAX is the sub-unit worst case.
- Arithmetic:
  - All field values are reduced into [0, PRIME−1]; the sub-unit returns reduced results.
  - Inputs ≥ PRIME are undefined behaviour and are not checked.
  - k=0 gives c1_inf=1 and C2=M.

Decomposition:
- Shared package ecc_pkg:
  - FSM state encoding.
  - Point-operation opcode (OP_ADD, OP_DBL).
  - Point struct {x, y, inf}.
  - Function mod_add/mod_sub.
- One sub-module, ecc_point_unit:
  - Handshake: op_req/op_ack, with opcode, operands and CURVE_A/PRIME parameters.
  - Computes λ, x3 and y3 with an iterative modular inverse (binary extended Euclid).
  - Inputs are never infinity, and never a degenerate pair.

Test Plan:
All scenarios use PRIME=17, CURVE_A=2, G=(5,1), which has order 19.
1. k=2, P=G, Y=3G=(10,6), M=G → C1=(6,3), C2=7G=(0,6); c1_inf=c2_inf=0; done exactly one cycle.
2. k=0, P=G, Y=(10,6), M=(6,3) → c1_inf=1, C1 coordinates 0; C2=(6,3).
3. k=1, P=G, Y=G, M=18G=(5,16) → C1=(5,1); c2_inf=1 (P + (−P) path).
4. start held high for 3 cycles with a different k each cycle → only the first is accepted; one done; results match the first k; a second start issued during busy does not alter the outputs.
5. rst_n=0 asserted mid-MUL2 for one cycle → next cycle busy=0, all outputs 0, no done. A fresh start with scenario-1 operands then yields scenario-1 results.
6. k=19 (KWIDTH=8), P=G → c1_inf=1. Also check KWIDTH=5, k=5'b11111 (31 ≡ 12): C1=12G=(0,11).
